// File: rtl/sha3_256_seq.sv
// Strobe sequencer for the SHA3-256 sponge unit. First block: ans NR*(PIPE_WAIT+1)+4 cycles after the handshake.
// Backpressure: in_ready is high only in IDLE/NEXT; upstream holds in_valid and in_data until it sees in_ready.
module sha3_256_seq #(
   parameter int RATE      = 1088,
   parameter int NR        = 24,
   parameter int PIPE_WAIT = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic            in_last,
   input  logic [RATE-1:0] in_data,
   output logic            in_ready,
   output logic [RATE-1:0] p,
   output logic            ovr_rst,
   output logic            rst1,
   output logic            sp,
   output logic            rst2,
   output logic            sp_keccak,
   output logic            ans,
   output logic            busy,
   output logic [4:0]      rnd,
   output logic            done
);
   localparam int WW = (PIPE_WAIT > 1) ? $clog2(PIPE_WAIT) : 1;

   typedef enum logic [3:0] {
      IDLE, CLR, LOAD, INIT, RWAIT, RSTEP, CAPT, NEXT, DONE
   } state_t;

   state_t          state, state_n;
   logic [RATE-1:0] p_n;
   logic            last_q, last_n;
   logic [4:0]      rnd_n;
   logic [WW-1:0]   wcnt, wcnt_n;
   logic            hs;
   logic            in_ready_n, rst1_n, sp_n, rst2_n, sp_keccak_n, ans_n, busy_n, done_n;

   assign hs = in_valid & in_ready;

   always_comb begin
      state_n = state;
      p_n     = p;
      last_n  = last_q;
      rnd_n   = rnd;
      wcnt_n  = wcnt;
      case (state)
         IDLE: begin
            if (hs) begin
               p_n     = in_data;
               last_n  = in_last;
               state_n = CLR;
            end
         end
         CLR:  state_n = LOAD;
         LOAD: begin
            rnd_n   = '0;
            state_n = INIT;
         end
         INIT: begin
            wcnt_n  = '0;
            state_n = RWAIT;
         end
         RWAIT: begin
            if (wcnt == WW'(PIPE_WAIT - 1)) state_n = RSTEP;
            else                            wcnt_n  = wcnt + 1'b1;
         end
         RSTEP: begin
            if (rnd == 5'(NR - 1)) begin
               state_n = CAPT;
            end else begin
               rnd_n   = rnd + 5'd1;
               wcnt_n  = '0;
               state_n = RWAIT;
            end
         end
         CAPT: state_n = last_q ? DONE : NEXT;
         // The sponge state is kept across blocks, so the next block skips CLR.
         NEXT: begin
            if (hs) begin
               p_n     = in_data;
               last_n  = in_last;
               state_n = LOAD;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase

      in_ready_n  = (state_n == IDLE) || (state_n == NEXT);
      rst1_n      = (state_n == CLR);
      sp_n        = (state_n == LOAD);
      rst2_n      = (state_n == LOAD) || (state_n == INIT);
      sp_keccak_n = (state_n == INIT) || (state_n == RSTEP);
      ans_n       = (state_n == CAPT);
      done_n      = (state_n == DONE);
      busy_n      = (state_n != IDLE);
   end

   always_ff @(posedge clk) begin
      ovr_rst <= ~rst;
      if (!rst) begin
         state     <= IDLE;
         p         <= '0;
         last_q    <= 1'b0;
         rnd       <= '0;
         wcnt      <= '0;
         in_ready  <= 1'b0;
         rst1      <= 1'b1;
         sp        <= 1'b0;
         rst2      <= 1'b0;
         sp_keccak <= 1'b0;
         ans       <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         p         <= p_n;
         last_q    <= last_n;
         rnd       <= rnd_n;
         wcnt      <= wcnt_n;
         in_ready  <= in_ready_n;
         rst1      <= rst1_n;
         sp        <= sp_n;
         rst2      <= rst2_n;
         sp_keccak <= sp_keccak_n;
         ans       <= ans_n;
         done      <= done_n;
         busy      <= busy_n;
      end
   end
endmodule

// File: tb/tb_sha3_256_seq.sv
// Directed bench for sha3_256_seq: expected strobe events are queued at each handshake and popped as the DUT emits them.
module tb_sha3_256_seq;
   localparam int RATE = 1088;
   localparam int NR   = 24;

   localparam logic [3:0] K_NONE = 4'd0, K_RST1 = 4'd1, K_SP = 4'd2, K_INIT = 4'd3,
                          K_STEP = 4'd4, K_ANS = 4'd5, K_DONE = 4'd6;

   typedef struct packed {
      logic [31:0] cyc;
      logic [3:0]  kind;
   } ev_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid, in_last;
   logic [RATE-1:0] in_data;
   logic            in_ready, ovr_rst, rst1, sp, rst2, sp_keccak, ans, busy, done;
   logic [RATE-1:0] p;
   logic [4:0]      rnd;

   logic            v3, l3;
   logic [RATE-1:0] d3;
   logic            rdy3, ovr3, r13, sp3, r23, sk3, ans3, busy3, done3;
   logic [RATE-1:0] p3;
   logic [4:0]      rnd3;

   int              cyc = 0;
   int              n_cmp = 0;
   int              n_bad = 0;
   logic            mon_en;
   logic [RATE-1:0] pexp, msg, a, b;
   ev_t             q1[$];
   ev_t             q3[$];

   sha3_256_seq #(.RATE(RATE), .NR(NR), .PIPE_WAIT(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
      .in_ready(in_ready), .p(p), .ovr_rst(ovr_rst), .rst1(rst1), .sp(sp), .rst2(rst2),
      .sp_keccak(sp_keccak), .ans(ans), .busy(busy), .rnd(rnd), .done(done)
   );

   sha3_256_seq #(.RATE(RATE), .NR(NR), .PIPE_WAIT(3)) dut3 (
      .clk(clk), .rst(rst), .in_valid(v3), .in_last(l3), .in_data(d3),
      .in_ready(rdy3), .p(p3), .ovr_rst(ovr3), .rst1(r13), .sp(sp3), .rst2(r23),
      .sp_keccak(sk3), .ans(ans3), .busy(busy3), .rnd(rnd3), .done(done3)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] fold32(input logic [RATE-1:0] v);
      logic [31:0] f = '0;
      for (int i = 0; i < RATE / 32; i++) f ^= v[i*32 +: 32];
      return f;
   endfunction

   task automatic chk_blk(input string tag, input logic [RATE-1:0] obs, input logic [RATE-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed fold %08h low %0h expected fold %08h low %0h",
                tag, fold32(obs), obs[127:0], fold32(exp), exp[127:0]);
      end
   endtask

   function automatic logic [RATE-1:0] rand_blk();
      logic [RATE-1:0] r;
      for (int i = 0; i < RATE / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic push(input int inst, input int t, input logic [3:0] k);
      ev_t e;
      e = '{cyc: 32'(t), kind: k};
      if (inst == 1) q1.push_back(e);
      else           q3.push_back(e);
   endtask

   // Expected strobe timeline for one block whose handshake falls in cycle h.
   task automatic push_block(input int inst, input int h, input bit first, input bit last);
      int t = h;
      int pw = (inst == 1) ? 1 : 3;
      if (first) begin t++; push(inst, t, K_RST1); end
      t++; push(inst, t, K_SP);
      t++; push(inst, t, K_INIT);
      for (int k = 0; k < NR; k++) begin t += pw + 1; push(inst, t, K_STEP); end
      t++; push(inst, t, K_ANS);
      if (last) begin t++; push(inst, t, K_DONE); end
   endtask

   task automatic obs_ev(input int inst, input logic [3:0] k);
      ev_t got, exp;
      got = '{cyc: 32'(cyc), kind: k};
      exp = '{cyc: 32'hFFFF_FFFF, kind: K_NONE};
      if (inst == 1) begin
         if (q1.size() != 0) exp = q1.pop_front();
      end else begin
         if (q3.size() != 0) exp = q3.pop_front();
      end
      chk(inst == 1 ? "event_dut1" : "event_dut3", 64'(got), 64'(exp));
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (rst1)      obs_ev(1, K_RST1);
         if (sp)        obs_ev(1, K_SP);
         if (sp_keccak) obs_ev(1, rst2 ? K_INIT : K_STEP);
         if (ans)       obs_ev(1, K_ANS);
         if (done)      obs_ev(1, K_DONE);
         if (r13)       obs_ev(3, K_RST1);
         if (sp3)       obs_ev(3, K_SP);
         if (sk3)       obs_ev(3, r23 ? K_INIT : K_STEP);
         if (ans3)      obs_ev(3, K_ANS);
         if (done3)     obs_ev(3, K_DONE);
      end
   end

   // Called just after a negedge; returns at the negedge after the handshake.
   task automatic send(input logic [RATE-1:0] d, input bit l, input bit first, input bit garble);
      int n = 0;
      in_valid = 1'b1;
      in_last  = l;
      in_data  = garble ? rand_blk() : d;
      while (!in_ready && n < 300) begin
         chk_blk("p_hold", p, pexp);
         @(negedge clk);
         n++;
         if (garble) in_data = rand_blk();
      end
      in_data = d;
      chk("handshake_wait", 64'(n < 300), 64'd1);
      push_block(1, cyc, first, l);
      pexp = d;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = rand_blk();
      chk_blk("p_latch", p, pexp);
   endtask

   task automatic drain();
      int n = 0;
      while ((q1.size() != 0 || q3.size() != 0) && n < 400) begin
         @(negedge clk);
         n++;
         if (ans) chk("rnd_at_capt", 64'(rnd), 64'(NR - 1));
      end
      chk("drain", 64'(q1.size() + q3.size()), 64'd0);
      @(negedge clk);
      chk("idle_busy", 64'(busy | busy3), 64'd0);
      chk("idle_ready", 64'(in_ready & rdy3), 64'd1);
   endtask

   initial begin
      int n;
      rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
      v3 = 1'b0; l3 = 1'b0; d3 = '0; mon_en = 1'b0; pexp = '0;
      msg = '0;
      msg[7:0] = 8'h06;
      msg[RATE-1 -: 8] = 8'h80;

      repeat (3) @(negedge clk);
      chk_blk("rst_p", p, '0);
      chk("rst_rnd", 64'(rnd), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_strobes", 64'({sp, sp_keccak, ans, done, rst2}), 64'd0);
      chk("rst_ovr_rst", 64'(ovr_rst), 64'd1);
      chk("rst_rst1", 64'(rst1), 64'd1);

      rst = 1'b1;
      @(negedge clk);
      chk("rel_rst1", 64'(rst1), 64'd0);
      chk("rel_ready", 64'(in_ready), 64'd1);
      chk("rel_ovr_rst", 64'(ovr_rst), 64'd0);
      mon_en = 1'b1;

      // Single padded final block.
      send(msg, 1'b1, 1'b1, 1'b0);
      drain();

      // Two chained blocks; second offered during rounds with changing data.
      a = rand_blk();
      b = rand_blk();
      send(a, 1'b0, 1'b1, 1'b0);
      send(b, 1'b1, 1'b0, 1'b1);
      drain();

      // Upstream stall of 10 cycles in NEXT.
      send(a, 1'b0, 1'b1, 1'b0);
      n = 0;
      while (!in_ready && n < 200) begin @(negedge clk); n++; end
      chk("reach_next", 64'(n < 200), 64'd1);
      repeat (10) begin
         chk("stall_busy", 64'(busy), 64'd1);
         chk("stall_ready", 64'(in_ready), 64'd1);
         @(negedge clk);
      end
      send(b, 1'b1, 1'b0, 1'b0);
      drain();

      // Reset while at round 10, then a fresh message.
      send(msg, 1'b1, 1'b1, 1'b0);
      n = 0;
      while (rnd != 5'd10 && n < 200) begin @(negedge clk); n++; end
      chk("reach_rnd10", 64'(n < 200), 64'd1);
      mon_en = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_strobes", 64'({sp, sp_keccak, ans, done, rst2}), 64'd0);
      chk("mid_rst1", 64'(rst1), 64'd1);
      chk("mid_rnd", 64'(rnd), 64'd0);
      chk("mid_busy", 64'(busy), 64'd0);
      chk("mid_ovr_rst", 64'(ovr_rst), 64'd1);
      q1.delete();
      q3.delete();
      pexp = '0;
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rel_rst1", 64'(rst1), 64'd0);
      chk("mid_rel_ready", 64'(in_ready), 64'd1);
      mon_en = 1'b1;
      send(msg, 1'b1, 1'b1, 1'b0);
      drain();

      // PIPE_WAIT=3 instance: steps 4 cycles apart.
      chk("pw3_ready", 64'(rdy3), 64'd1);
      d3 = msg;
      l3 = 1'b1;
      v3 = 1'b1;
      push_block(3, cyc, 1'b1, 1'b1);
      @(negedge clk);
      v3 = 1'b0;
      d3 = '0;
      chk_blk("pw3_p", p3, msg);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
